// File: rtl/ber_monitor.sv
// Windowed bit-error-rate monitor for the 64-bit PRBS7 receive path.
// Optional running totals are compiled in when BER_MONITOR_TOTALS_EN is defined.
module ber_monitor #(
    parameter int WORDWIDTH   = 64,
    parameter int WINDOW_LOG2 = 10,
    parameter int SETTLE      = 16,
    parameter int ERR_THRESH  = 16,
    parameter int BAD_WINDOWS = 4,
    parameter int TOT_WIDTH   = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     aligned,
    input  logic [WORDWIDTH-1:0]     errorBits,
    output logic [WINDOW_LOG2+6:0]   win_err_count,
    output logic                     win_done,
    output logic [3:0]               bad_streak,
    output logic                     locked,
    output logic                     realign,
    output logic [TOT_WIDTH-1:0]     tot_err_count,
    output logic [TOT_WIDTH-1:0]     tot_word_count
);
    localparam int CW = WINDOW_LOG2 + 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [7:0]             settle_cnt;
    logic [WINDOW_LOG2-1:0] word_cnt;
    logic                   p1_valid, p1_last;
    logic [6:0]             p1_pop;
    logic [CW-1:0]          acc;
    logic                   p2_valid;
    logic [CW-1:0]          p2_sum;
    logic                   measuring;
    logic                   window_bad;
    logic [3:0]             streak_next;
    logic                   hit_limit;

    function automatic logic [6:0] popcount(input logic [WORDWIDTH-1:0] w);
        logic [6:0] s;
        s = '0;
        for (int i = 0; i < WORDWIDTH; i++) s = s + 7'(w[i]);
        return s;
    endfunction

    assign measuring   = (state == S_MEASURE) && aligned;
    assign window_bad  = p2_sum > CW'(ERR_THRESH);
    assign streak_next = window_bad ? ((bad_streak == 4'hF) ? 4'hF : bad_streak + 4'd1) : 4'd0;
    // A window reporting after the link already dropped only updates the streak.
    assign hit_limit   = p2_valid && (state == S_MEASURE) && (streak_next == 4'(BAD_WINDOWS));
    assign locked      = (state == S_MEASURE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (aligned) state_next = (SETTLE <= 1) ? S_MEASURE : S_SETTLE;
            S_SETTLE: begin
                if (!aligned)                           state_next = S_IDLE;
                else if (settle_cnt == 8'(SETTLE - 1))  state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (hit_limit)     state_next = S_LOST;
                else if (!aligned) state_next = S_IDLE;
            end
            S_LOST:    if (!aligned) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            settle_cnt    <= '0;
            word_cnt      <= '0;
            p1_valid      <= 1'b0;
            p1_last       <= 1'b0;
            p1_pop        <= '0;
            acc           <= '0;
            p2_valid      <= 1'b0;
            p2_sum        <= '0;
            win_err_count <= '0;
            win_done      <= 1'b0;
            bad_streak    <= '0;
            realign       <= 1'b0;
        end else begin
            state <= state_next;

            // The word that moves IDLE into SETTLE counts as the first settle word.
            if (state == S_IDLE)                  settle_cnt <= 8'd1;
            else if (state == S_SETTLE && aligned) settle_cnt <= settle_cnt + 8'd1;

            p1_valid <= measuring;
            if (measuring) begin
                p1_pop   <= popcount(errorBits);
                p1_last  <= &word_cnt;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                word_cnt <= '0;
            end

            // A closing word always completes its window, even across a link drop.
            if (p1_valid && p1_last) begin
                p2_valid <= 1'b1;
                p2_sum   <= acc + CW'(p1_pop);
                acc      <= '0;
            end else begin
                p2_valid <= 1'b0;
                if (!measuring)    acc <= '0;
                else if (p1_valid) acc <= acc + CW'(p1_pop);
            end

            win_done <= p2_valid;
            realign  <= hit_limit;
            if (p2_valid) begin
                win_err_count <= p2_sum;
                bad_streak    <= streak_next;
            end else if (state == S_IDLE) begin
                bad_streak <= '0;
            end
        end
    end

`ifdef BER_MONITOR_TOTALS_EN
    logic [TOT_WIDTH:0] err_sum;
    assign err_sum = {1'b0, tot_err_count} + (TOT_WIDTH + 1)'(p1_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            tot_err_count  <= '0;
            tot_word_count <= '0;
        end else if (p1_valid) begin
            tot_err_count <= err_sum[TOT_WIDTH] ? {TOT_WIDTH{1'b1}} : err_sum[TOT_WIDTH-1:0];
            if (tot_word_count != {TOT_WIDTH{1'b1}}) tot_word_count <= tot_word_count + 1'b1;
        end
    end
`else
    assign tot_err_count  = '0;
    assign tot_word_count = '0;
`endif

endmodule

// File: tb/tb_ber_monitor.sv
// Directed bench for ber_monitor: window table, link loss, mid-window drop and saturation.
// Totals expectations follow BER_MONITOR_TOTALS_EN.
module tb_ber_monitor;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef BER_MONITOR_TOTALS_EN
    localparam bit TOT_ON = 1'b1;
`else
    localparam bit TOT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, aligned;
    logic [63:0] errorBits;
    logic [16:0] win_err_count;
    logic        win_done, locked, realign;
    logic [3:0]  bad_streak;
    logic [47:0] tot_err_count, tot_word_count;

    logic        s_reset, s_aligned;
    logic [63:0] s_errbits;
    logic [10:0] s_win_err_count;
    logic        s_win_done, s_locked, s_realign;
    logic [3:0]  s_bad_streak;
    logic [7:0]  s_tot_err, s_tot_word;

    ber_monitor dut (
        .clk(clk), .reset(reset), .aligned(aligned), .errorBits(errorBits),
        .win_err_count(win_err_count), .win_done(win_done), .bad_streak(bad_streak),
        .locked(locked), .realign(realign),
        .tot_err_count(tot_err_count), .tot_word_count(tot_word_count)
    );

    ber_monitor #(.WINDOW_LOG2(4), .SETTLE(2), .TOT_WIDTH(8)) u_sat (
        .clk(clk), .reset(s_reset), .aligned(s_aligned), .errorBits(s_errbits),
        .win_err_count(s_win_err_count), .win_done(s_win_done), .bad_streak(s_bad_streak),
        .locked(s_locked), .realign(s_realign),
        .tot_err_count(s_tot_err), .tot_word_count(s_tot_word)
    );

    typedef struct packed {
        logic [16:0] cnt;
        logic [3:0]  streak;
        logic        realign;
        logic        locked;
        logic [10:0] gap;
    } exp_t;

    typedef struct {
        logic [63:0] e0;
        logic [63:0] e1;
        logic [16:0] cnt;
        logic [3:0]  streak;
        logic        realign;
        logic        locked;
        logic [10:0] gap;
        logic        tot_chk;
        logic [47:0] tot_words;
        logic [47:0] tot_errs;
    } win_vec_t;

    exp_t     exp_q[$];
    win_vec_t tbl[8];
    int       n_checks = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       last_done = 0;
    int       realign_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] tot(input logic [63:0] v);
        return TOT_ON ? v : 64'd0;
    endfunction

    // Scoreboard: every win_done pops one expected window report.
    always @(negedge clk) begin
        exp_t e;
        if (realign && !win_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL realign_alone: got realign=1 without win_done, expected none (cycle %0d)", cyc);
        end
        if (realign) realign_pulses++;
        if (win_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_win_done: got win_done=1 count=%0d, expected none (cycle %0d)",
                         win_err_count, cyc);
            end else begin
                e = exp_q.pop_front();
                check("win_err_count", 64'(win_err_count), 64'(e.cnt));
                check("bad_streak", 64'(bad_streak), 64'(e.streak));
                check("realign_at_done", 64'(realign), 64'(e.realign));
                check("locked_at_done", 64'(locked), 64'(e.locked));
                if (e.gap != 0) check("win_gap", 64'(cyc - last_done), 64'(e.gap));
            end
            last_done = cyc;
        end
    end

    task automatic drive(input logic al, input logic [63:0] e);
        aligned   = al;
        errorBits = e;
        @(posedge clk);
        #1;
    endtask

    task automatic sdrive(input logic al, input logic [63:0] e);
        s_aligned = al;
        s_errbits = e;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input win_vec_t v);
        exp_q.push_back('{cnt: v.cnt, streak: v.streak, realign: v.realign,
                          locked: v.locked, gap: v.gap});
        for (int k = 0; k < 1024; k++) begin
            drive(1'b1, (k == 0) ? v.e0 : (k == 1) ? v.e1 : 64'h0);
            if (k == 0 && v.tot_chk) begin
                check("tot_word_at_window_start", 64'(tot_word_count), tot(64'(v.tot_words)));
                check("tot_err_at_window_start", 64'(tot_err_count), tot(64'(v.tot_errs)));
            end
        end
    endtask

    task automatic relock;
        for (int k = 0; k < 15; k++) drive(1'b1, 64'h0);
        check("locked_before_16th_word", 64'(locked), 64'd0);
        drive(1'b1, 64'h0);
        check("locked_after_16_words", 64'(locked), 64'd1);
    endtask

    initial begin
        win_vec_t v;
        //          e0         e1     cnt  strk rlgn lock gap   chk words  errs
        tbl[0] = '{64'h0,     64'h0, 17'd0,  4'd0, 1'b0, 1'b1, 11'd0,    1'b1, 48'd0,    48'd0};
        tbl[1] = '{64'h0,     64'h0, 17'd0,  4'd0, 1'b0, 1'b1, 11'd1024, 1'b0, 48'd0,    48'd0};
        tbl[2] = '{64'h1,     ONES,  17'd65, 4'd1, 1'b0, 1'b1, 11'd1024, 1'b1, 48'd2048, 48'd0};
        tbl[3] = '{64'h0,     64'h0, 17'd0,  4'd0, 1'b0, 1'b1, 11'd1024, 1'b0, 48'd0,    48'd0};
        tbl[4] = '{64'h1FFFF, 64'h0, 17'd17, 4'd1, 1'b0, 1'b1, 11'd1024, 1'b1, 48'd4096, 48'd65};
        tbl[5] = '{64'h1FFFF, 64'h0, 17'd17, 4'd2, 1'b0, 1'b1, 11'd1024, 1'b0, 48'd0,    48'd0};
        tbl[6] = '{64'h1FFFF, 64'h0, 17'd17, 4'd3, 1'b0, 1'b1, 11'd1024, 1'b0, 48'd0,    48'd0};
        tbl[7] = '{64'h1FFFF, 64'h0, 17'd17, 4'd4, 1'b1, 1'b0, 11'd1024, 1'b0, 48'd0,    48'd0};

        reset = 1'b1; aligned = 1'b0; errorBits = '0;
        s_reset = 1'b1; s_aligned = 1'b0; s_errbits = '0;

        // Saturation on the narrow-total instance (SETTLE=2, TOT_WIDTH=8).
        sdrive(1'b0, 64'h0);
        sdrive(1'b0, 64'h0);
        s_reset = 1'b0;
        sdrive(1'b1, 64'h0);
        sdrive(1'b1, 64'h0);
        check("sat_locked", 64'(s_locked), 64'd1);
        for (int k = 0; k < 4; k++) sdrive(1'b1, ONES);
        check("sat_tot_err_192", 64'(s_tot_err), tot(64'd192));
        sdrive(1'b1, ONES);
        check("sat_tot_err_clamped", 64'(s_tot_err), tot(64'd255));
        for (int k = 0; k < 3; k++) sdrive(1'b1, 64'h0);
        check("sat_tot_err_holds", 64'(s_tot_err), tot(64'd255));
        check("sat_tot_word", 64'(s_tot_word), tot(64'd7));
        s_aligned = 1'b0;

        // Reset state of the main instance.
        for (int k = 0; k < 4; k++) drive(1'b0, 64'h0);
        reset = 1'b0;
        drive(1'b0, 64'h0);
        check("rst_win_err_count", 64'(win_err_count), 64'd0);
        check("rst_win_done", 64'(win_done), 64'd0);
        check("rst_bad_streak", 64'(bad_streak), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_realign", 64'(realign), 64'd0);
        check("rst_tot_err", 64'(tot_err_count), 64'd0);
        check("rst_tot_word", 64'(tot_word_count), 64'd0);

        relock();
        for (int i = 0; i < 8; i++) run_window(tbl[i]);

        // Link loss: LOST holds until aligned drops, then IDLE clears the streak.
        for (int k = 0; k < 4; k++) drive(1'b1, 64'h0);
        check("lost_locked", 64'(locked), 64'd0);
        check("lost_streak_held", 64'(bad_streak), 64'd4);
        check("realign_pulses_once", 64'(realign_pulses), 64'd1);
        drive(1'b0, 64'h0);
        drive(1'b0, 64'h0);
        check("idle_streak_cleared", 64'(bad_streak), 64'd0);
        relock();

        // Drop at word 500: nothing reported, totals keep words 0..499.
        for (int k = 0; k < 500; k++) drive(1'b1, (k == 3) ? ONES : 64'h0);
        drive(1'b0, 64'h0);
        drive(1'b0, 64'h0);
        check("drop_locked", 64'(locked), 64'd0);
        check("drop_tot_word", 64'(tot_word_count), tot(64'd8694));
        check("drop_tot_err", 64'(tot_err_count), tot(64'd197));
        relock();

        v = '{64'h3FFFF, 64'h0, 17'd18, 4'd1, 1'b0, 1'b1, 11'd0, 1'b1, 48'd8694, 48'd197};
        run_window(v);
        // Drop right after the closing word: the window still reports.
        v = '{64'h1F, 64'h0, 17'd5, 4'd0, 1'b0, 1'b0, 11'd1024, 1'b0, 48'd0, 48'd0};
        run_window(v);
        for (int k = 0; k < 3; k++) drive(1'b0, 64'h0);
        check("final_tot_word", 64'(tot_word_count), tot(64'd10742));
        check("final_tot_err", 64'(tot_err_count), tot(64'd220));

        repeat (4) @(posedge clk);
        #1;
        check("all_windows_reported", 64'(exp_q.size()), 64'd0);
        check("realign_pulses_total", 64'(realign_pulses), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ber_monitor.md
# ber_monitor

Windowed bit-error-rate monitor for the 64-bit PRBS7 receive path. Sits directly downstream of the frame aligner/checker in the RX `gt0_rxusrclk2_i` domain. Consumes the aligner's per-word `errorBits` mask and `aligned` flag. Produces per-window and running error totals, a lock indication, and a one-cycle `realign` request when the link degrades persistently.

## Interface
Parameters:
- `WORDWIDTH`, 64: width of the error-bit mask; popcount range is 0..64.
- `WINDOW_LOG2`, 10: window length is 2^WINDOW_LOG2 words.
- `SETTLE`, 16: words discarded after `aligned` rises, before measurement starts (1..255).
- `ERR_THRESH`, 16: a window is bad when its error count is strictly greater than this.
- `BAD_WINDOWS`, 4: consecutive bad windows that trigger `realign` (1..15).
- `TOT_WIDTH`, 48: width of the running totals.

Ports:
- `clk` in 1: RX user clock (driven from `gt0_rxusrclk2_i`).
- `reset` in 1: synchronous, active-high.
- `aligned` in 1: aligner lock flag.
- `errorBits` in WORDWIDTH: per-bit mismatch mask for the current word. Sampled every cycle.
- `win_err_count` out WINDOW_LOG2+7: error count of the last completed window. Reset value 0.
- `win_done` out 1: one-cycle pulse when `win_err_count` updates. Reset value 0.
- `bad_streak` out 4: current count of consecutive bad windows. Reset value 0.
- `locked` out 1: high while in MEASURE. Reset value 0.
- `realign` out 1: one-cycle request to the aligner to restart its search. Reset value 0.
- `tot_err_count` out TOT_WIDTH: saturating total of errored bits. Reset value 0.
- `tot_word_count` out TOT_WIDTH: saturating total of measured words. Reset value 0.

## Operation
States and transitions:
- IDLE
  - Counters cleared except the totals.
  - `aligned`=1 → SETTLE.
- SETTLE
  - Counts `SETTLE` words with `aligned`=1, then → MEASURE.
  - `aligned`=0 → IDLE.
- MEASURE
  - Each cycle, the word is sampled into the popcount stage, tagged with a last-of-window flag.
  - The word counter wraps from 2^WINDOW_LOG2−1 to 0.
  - `aligned`=0 → IDLE. The window in progress is discarded: accumulator and word counter cleared, pipeline valid bits flushed, no `win_done`.
- LOST
  - Entered when `bad_streak` reaches `BAD_WINDOWS`.
  - `realign` pulses on entry only.
  - Stays in LOST until `aligned`=0, then → IDLE.
  - Words are not measured in LOST.

Window close (last tagged word reaches the accumulate stage):
- `win_err_count` ← accumulator + last popcount; accumulator ← 0 in the same cycle.
- `win_err_count` > `ERR_THRESH`: `bad_streak`+1. Otherwise `bad_streak` ← 0.
- Reaching `BAD_WINDOWS` causes the MEASURE→LOST transition at the same edge that `win_done` rises.

Arithmetic and reset:
- Popcount is a full 7-bit sum. The window accumulator is WINDOW_LOG2+7 bits and cannot overflow.
- Totals add popcount/1 per measured word. Each total saturates at all-ones and holds.
- `reset` overrides everything: state → IDLE, all outputs to their reset values, totals cleared.

## Timing
- Word sampled at edge N (MEASURE, `aligned`=1): popcount registered at N; added into the accumulator at N+1; totals updated at N+1.
- Last word of a window sampled at edge N: `win_err_count`, `win_done`, `bad_streak` valid after edge N+2. `win_done` is high for exactly that one cycle.
- `realign` asserts in the same cycle as the `win_done` that completes the bad streak. `locked` falls in that same cycle.
- `locked` rises the cycle after the SETTLE count completes. It falls in the cycle after `aligned` is sampled low.
- Windows are back-to-back. The first word of the next window is sampled at edge N+1 with no gap.
- `aligned` falling at the same edge a window closes: the closing window still completes and reports. Words sampled after the drop are not counted.

## Configuration
- `BER_MONITOR_TOTALS_EN` defined: both TOT_WIDTH accumulators and their saturation logic are compiled in.
- Not defined: `tot_err_count` and `tot_word_count` are constant 0, and their logic is removed. Window, streak and state machine behaviour are unchanged.

## Test plan
- Clean lock: `reset` for 4 cycles, then `aligned`=1 with `errorBits`=0.
  - `locked`=1 after 16 words.
  - `win_done` every 1024 cycles with `win_err_count`=0.
  - `tot_word_count`=2048 after two windows.
- Single-bit errors: one word with `errorBits`=64'h1 and one with 64'hFFFF_FFFF_FFFF_FFFF in a window.
  - `win_err_count`=65 and `bad_streak`=1 (threshold 16).
  - Next clean window → `bad_streak`=0.
- Loss of link: 17 errored bits per window for 4 consecutive windows.
  - `realign` pulses once, together with the 4th `win_done`; `locked`=0.
  - Then `aligned`=0 → IDLE; `aligned`=1 → SETTLE again.
- Mid-window drop: `aligned`=0 at word 500 of a window.
  - No `win_done`; accumulator cleared.
  - Totals retain words 0..499.
  - After re-lock, the next window reports only new errors.
- Saturation (TOT_WIDTH=8, macro defined): all-ones `errorBits` for 5 words → `tot_err_count`=255 and stays 255.
- Macro undefined: same stimulus as the clean-lock case → totals stay 0; window outputs identical to the clean-lock case.
